// File: rtl/skeleton_writeback.sv
// rtl/skeleton_writeback.sv - frame writeback buffer with per-frame change/foreground statistics
//
// Captures one frame of pixels from the convolution stage into a register buffer.
// Each frame also yields a change flag, a foreground count and an iteration count.
// The next iteration reloads the stored frame through the registered read port.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   wr_en             - write stream valid; a frame is one contiguous burst of wr_en=1
//   wr_addr, wr_data  - pixel address/value; each address is held for 2 cycles upstream
//   rd_addr, rd_data  - readback port, 1-cycle latency, out-of-range reads return 0
//   frame_done        - one-cycle pulse when a frame completes
//   changed           - last completed frame differed from what it overwrote
//   converged         - inverse of changed for the last completed frame
//   fg_count          - nonzero pixels written in the last completed frame
//   iter_count        - completed frames, saturating at 255
//   addr_err          - sticky: an out-of-range write was seen since reset
module skeleton_writeback #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [bitSize:0]      wr_addr,
    input  logic [pixelWidth-1:0] wr_data,
    input  logic [bitSize:0]      rd_addr,
    output logic [pixelWidth-1:0] rd_data,
    output logic                  frame_done,
    output logic                  changed,
    output logic                  converged,
    output logic [bitSize+1:0]    fg_count,
    output logic [7:0]            iter_count,
    output logic                  addr_err
);

    localparam int DEPTH = N * N;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW    = bitSize + 1;
    localparam int CW    = bitSize + 2;
    // One bit wider than the address so DEPTH itself is representable.
    localparam logic [AW:0] DEPTH_EXT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [pixelWidth-1:0] buf_q [DEPTH];
    logic [pixelWidth-1:0] buf_d [DEPTH];
    logic [bitSize:0]      last_addr_q, last_addr_d;
    logic                  last_vld_q, last_vld_d;
    logic                  chg_q, chg_d;
    logic [CW-1:0]         fgc_q, fgc_d;
    logic [pixelWidth-1:0] rd_data_q, rd_data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  changed_q, changed_d;
    logic                  converged_q, converged_d;
    logic [CW-1:0]         fg_count_q, fg_count_d;
    logic [7:0]            iter_q, iter_d;
    logic                  addr_err_q, addr_err_d;

    logic                  accept;
    logic                  first_wr;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [pixelWidth-1:0] old_pix;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    assign wr_idx      = wr_addr[IW-1:0];
    assign rd_idx      = rd_addr[IW-1:0];
    assign old_pix     = buf_q[wr_idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (wr_en)  state_d = S_CAPTURE;
            S_CAPTURE: if (!wr_en) state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Output/decode logic. The IDLE cycle with wr_en=1 is itself the first write
    // of the frame; later writes are taken only when the address moves on, which
    // collapses the upstream 2-cycle address hold into one write per pixel.
    always_comb begin
        first_wr = (state_q == S_IDLE);
        accept   = 1'b0;
        if (wr_en) begin
            if (state_q == S_IDLE) begin
                accept = 1'b1;
            end else if (state_q == S_CAPTURE) begin
                accept = !last_vld_q || (wr_addr != last_addr_q);
            end
        end
    end

    // Datapath
    always_comb begin
        buf_d        = buf_q;
        last_addr_d  = last_addr_q;
        last_vld_d   = last_vld_q;
        chg_d        = chg_q;
        fgc_d        = fgc_q;
        addr_err_d   = addr_err_q;
        changed_d    = changed_q;
        converged_d  = converged_q;
        fg_count_d   = fg_count_q;
        iter_d       = iter_q;
        frame_done_d = 1'b0;

        if (accept) begin
            last_addr_d = wr_addr;
            last_vld_d  = 1'b1;
            // Frame-local statistics restart on the first write, before it is counted.
            if (first_wr) begin
                chg_d = 1'b0;
                fgc_d = '0;
            end
            if (wr_in_range) begin
                buf_d[wr_idx] = wr_data;
                if (wr_data != old_pix) chg_d = 1'b1;
                if (wr_data != '0)      fgc_d = fgc_d + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                addr_err_d = 1'b1;
            end
        end

        // Publish the frame results on the edge that enters DONE, so the outputs
        // are already valid during the frame_done pulse.
        if (state_q == S_CAPTURE && !wr_en) begin
            frame_done_d = 1'b1;
            changed_d    = chg_q;
            converged_d  = ~chg_q;
            fg_count_d   = fgc_q;
            if (iter_q != 8'hFF) iter_d = iter_q + 8'd1;
        end

        if (state_q == S_DONE) last_vld_d = 1'b0;

        // Reads see buf_q, so a same-cycle write to the same pixel is not visible yet.
        rd_data_d = rd_in_range ? buf_q[rd_idx] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q        <= '{default: '0};
            last_addr_q  <= '0;
            last_vld_q   <= 1'b0;
            chg_q        <= 1'b0;
            fgc_q        <= '0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            converged_q  <= 1'b0;
            fg_count_q   <= '0;
            iter_q       <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            last_addr_q  <= last_addr_d;
            last_vld_q   <= last_vld_d;
            chg_q        <= chg_d;
            fgc_q        <= fgc_d;
            rd_data_q    <= rd_data_d;
            frame_done_q <= frame_done_d;
            changed_q    <= changed_d;
            converged_q  <= converged_d;
            fg_count_q   <= fg_count_d;
            iter_q       <= iter_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign changed    = changed_q;
    assign converged  = converged_q;
    assign fg_count   = fg_count_q;
    assign iter_count = iter_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_skeleton_writeback.sv
// tb/tb_skeleton_writeback.sv - self-checking bench for skeleton_writeback
module tb_skeleton_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done;
    logic       changed;
    logic       converged;
    logic [7:0] fg_count;
    logic [7:0] iter_count;
    logic       addr_err;

    skeleton_writeback #(.N(8), .bitSize(6), .pixelWidth(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .changed    (changed),
        .converged  (converged),
        .fg_count   (fg_count),
        .iter_count (iter_count),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic chg;
        int   fg;
        int   iter;
        logic err;
    } exp_t;

    exp_t       fq[$];
    logic [7:0] rdq[$];
    logic [7:0] model [64];
    logic [7:0] fdata [64];
    int         m_iter;
    logic       m_err;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] model_rd(input int a);
        return (a < 64) ? model[a] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        m_iter = 0;
        m_err  = 1'b0;
        rdq.delete();
        fq.delete();
    endtask

    // One pixel, address held 2 cycles. The read port points at the same pixel
    // on the write cycle, so the value seen must be the pre-write contents.
    task automatic write_pixel(input int a, input logic [7:0] d, inout logic chg, inout int fg);
        logic [7:0] e;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[6:0];
        wr_data = d;
        rd_addr = a[6:0];
        rdq.push_back(model_rd(a));
        if (a < 64) begin
            if (model[a] !== d) chg = 1'b1;
            if (d != 8'h00) fg++;
            model[a] = d;
        end else begin
            m_err = 1'b1;
        end
        @(negedge clk);
        e = rdq.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_same_cycle addr=%0d got=%h exp=%h", a, rd_data, e);
        end
    endtask

    task automatic read_check(input int a, input string name);
        logic [7:0] e;
        @(negedge clk);
        rd_addr = a[6:0];
        rdq.push_back(model_rd(a));
        @(negedge clk);
        e = rdq.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL %s addr=%0d got=%h exp=%h", name, a, rd_data, e);
        end
    endtask

    task automatic wait_frame(input bit poke);
        int   n;
        exp_t x;
        bit   extra;
        n = 0;
        while (frame_done !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        x = fq.pop_front();
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_timeout got=%b exp=1", frame_done);
        end else begin
            checks += 5;
            if (changed !== x.chg) begin
                errors++;
                $display("FAIL changed got=%b exp=%b", changed, x.chg);
            end
            if (converged !== ~x.chg) begin
                errors++;
                $display("FAIL converged got=%b exp=%b", converged, ~x.chg);
            end
            if (fg_count !== 8'(x.fg)) begin
                errors++;
                $display("FAIL fg_count got=%0d exp=%0d", fg_count, x.fg);
            end
            if (iter_count !== 8'(x.iter)) begin
                errors++;
                $display("FAIL iter_count got=%0d exp=%0d", iter_count, x.iter);
            end
            if (addr_err !== x.err) begin
                errors++;
                $display("FAIL addr_err got=%b exp=%b", addr_err, x.err);
            end
        end
        if (poke) begin
            wr_en   = 1'b1;
            wr_addr = 7'd5;
            wr_data = 8'hAA;
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width got=%b exp=0", frame_done);
        end
        if (poke) begin
            extra = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (frame_done !== 1'b0) extra = 1'b1;
            end
            checks++;
            if (extra) begin
                errors++;
                $display("FAIL done_poke_frame got=1 exp=0");
            end
            read_check(5, "done_poke_ignored");
        end
    endtask

    task automatic send_frame(input int bad_pos, input bit poke);
        logic chg;
        int   fg;
        exp_t x;
        chg = 1'b0;
        fg  = 0;
        for (int a = 0; a < 64; a++) begin
            write_pixel(a, fdata[a], chg, fg);
            if (a == bad_pos) write_pixel(64, 8'h5A, chg, fg);
        end
        m_iter = (m_iter < 255) ? m_iter + 1 : 255;
        x.chg  = chg;
        x.fg   = fg;
        x.iter = m_iter;
        x.err  = m_err;
        fq.push_back(x);
        wr_en = 1'b0;
        wait_frame(poke);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({rd_data, frame_done, changed, converged, fg_count, iter_count, addr_err} !== 29'd0) begin
            errors++;
            $display("FAIL %s rd=%h fd=%b chg=%b conv=%b fg=%0d it=%0d err=%b exp=all0",
                     name, rd_data, frame_done, changed, converged, fg_count, iter_count, addr_err);
        end
    endtask

    task automatic test_reset();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        rst     = 1'b1;
        model_reset();
        #1;
        check_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_check(0, "reset_buf0");
        read_check(63, "reset_buf63");
        check_all_zero("post_reset_outputs");
    endtask

    task automatic test_zero_frame();
        for (int i = 0; i < 64; i++) fdata[i] = 8'h00;
        send_frame(-1, 1'b0);
    endtask

    task automatic test_pattern();
        for (int i = 0; i < 64; i++) fdata[i] = (i >= 9 && i <= 14) ? 8'hFF : 8'h00;
        send_frame(-1, 1'b0);
        read_check(9, "rd_pix9");
        read_check(8, "rd_pix8");
        read_check(14, "rd_pix14");
        read_check(100, "rd_out_of_range");
    endtask

    task automatic test_resend();
        send_frame(-1, 1'b1);
    endtask

    task automatic test_addr_err();
        fdata[20] = 8'h33;
        send_frame(31, 1'b0);
        read_check(0, "addr_err_buf0");
        read_check(20, "addr_err_buf20");
        send_frame(-1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic chg;
        int   fg;
        bit   seen;
        chg = 1'b0;
        fg  = 0;
        for (int a = 0; a < 30; a++) write_pixel(a, 8'h77, chg, fg);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 7'd30;
        wr_data = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_frame_outputs");
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_no_done got=1 exp=0");
        end
        read_check(10, "reset_mid_buf10");
        for (int i = 0; i < 64; i++) fdata[i] = (i % 7 == 3) ? 8'(i) : 8'h00;
        send_frame(-1, 1'b0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 64; i++) fdata[i] = 8'h00;
        for (int f = 0; f < 256; f++) send_frame(-1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_pattern();
        test_resend();
        test_addr_err();
        test_reset_mid_frame();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skeleton_writeback.md
SKELETON_WRITEBACK -- requirements
Module: skeleton_writeback

Interface
REQ-001 SHALL have parameter N, default 8: image side in pixels; frame holds N*N pixels, padding border included.
REQ-002 SHALL have parameter bitSize, default 6: address MSB index; address width is bitSize+1.
REQ-003 SHALL have parameter pixelWidth, default 8: pixel width in bits.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1: write stream valid; driven by the convolution stage's write-out enable.
REQ-007 SHALL have port wr_addr, input, bitSize+1: write pixel address.
REQ-008 SHALL have port wr_data, input, pixelWidth: write pixel value.
REQ-009 SHALL have port rd_addr, input, bitSize+1: readback address for reloading the next iteration.
REQ-010 SHALL have port rd_data, output, pixelWidth: readback pixel, registered.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse at end of a captured frame.
REQ-012 SHALL have port changed, output, 1: last completed frame differed from the buffer contents it overwrote.
REQ-013 SHALL have port converged, output, 1: last completed frame had changed=0.
REQ-014 SHALL have port fg_count, output, bitSize+2: count of nonzero pixels in the last completed frame.
REQ-015 SHALL have port iter_count, output, 8: number of completed frames, saturating at 255.
REQ-016 SHALL have port addr_err, output, 1: sticky flag set by an out-of-range write.

Function
REQ-017 SHALL hold an internal N*N x pixelWidth frame buffer in registers.
REQ-018 SHALL implement the states IDLE, CAPTURE and DONE.
REQ-019 IDLE->CAPTURE SHALL occur on the first cycle wr_en=1; that cycle is an accepted write.
REQ-020 CAPTURE->DONE SHALL occur on the first cycle wr_en=0.
REQ-021 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-022 A write SHALL be accepted only when:
- wr_en=1, and
- it is the first write of the frame, or wr_addr differs from the last accepted address.
Upstream holds each address for 2 cycles; repeated addresses SHALL be ignored.
REQ-023 An accepted write with wr_addr < N*N SHALL update buffer[wr_addr] at that clock edge.
REQ-024 On an accepted in-range write, if wr_data != old buffer[wr_addr], a frame-local change flag SHALL be set.
REQ-025 On an accepted in-range write, if wr_data != 0, a frame-local foreground counter SHALL increment.
REQ-026 An accepted write with wr_addr >= N*N SHALL not modify the buffer, SHALL set addr_err, and SHALL not affect the change flag or foreground counter.
REQ-027 On entry to CAPTURE, the change flag and foreground counter SHALL clear before the first write is counted.
REQ-028 In DONE:
- frame_done=1 for exactly one cycle;
- changed, converged=~changed and fg_count load from the frame-local values;
- iter_count increments, saturating at 255.
REQ-029 changed, converged and fg_count SHALL hold their values until the next DONE.
REQ-030 wr_en=1 during DONE SHALL be ignored; the next frame starts from IDLE on a later wr_en=1 cycle.
REQ-031 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented (1-cycle latency).
REQ-032 rd_addr >= N*N SHALL return 0.
REQ-033 When a read and a write address the same pixel in the same cycle, read SHALL return the pre-write value.
REQ-034 addr_err SHALL clear only on reset.

Reset
REQ-035 On rst=1, asynchronously:
- state=IDLE;
- buffer all zeros;
- rd_data=0, frame_done=0, changed=0, converged=0, fg_count=0, iter_count=0, addr_err=0;
- frame-local flag and counter cleared; last-address register invalid.
REQ-036 Reset asserted mid-CAPTURE SHALL abandon the frame: no frame_done pulse and no iter_count increment.

Verification
REQ-037 After reset, a 64-pixel frame is written with each address held 2 cycles, all data 0 -> frame_done pulses once; changed=0, converged=1, fg_count=0, iter_count=1.
REQ-038 A frame with pixels 9..14 = 0xFF and all others 0 -> changed=1, fg_count=6; reading rd_addr=9 gives 0xFF one cycle later, rd_addr=8 gives 0.
REQ-039 The identical frame is resent -> changed=0, converged=1, fg_count=6, iter_count incremented.
REQ-040 A write to wr_addr=64 mid-frame -> addr_err=1, buffer unchanged, fg_count unaffected; addr_err persists through the next frame.
REQ-041 rst is pulsed at address 30 of a frame -> all outputs 0 immediately, no frame_done; a subsequent full frame gives iter_count=1.
REQ-042 256 all-zero frames are sent -> iter_count saturates at 255, and frame_done still pulses on every frame.
